// File: rtl/regbank_pkg.sv
// Shared types and sizing for the register-bank write sequencer.
// The bank depth is fixed at 2**SEL_W so the index wraps with a plain decoder.
package regbank_pkg;

    localparam int N_REGS = 8;
    localparam int SEL_W  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } loader_state_t;

    typedef logic [SEL_W-1:0] reg_idx_t;

endpackage

// File: rtl/wrap_counter.sv
// Modulo-N_REGS bank index: load takes priority over increment, and the
// count wraps from N_REGS-1 back to 0.
module wrap_counter #(
    parameter int SEL_W  = 3,
    parameter int N_REGS = 2 ** SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [SEL_W-1:0] load_val,
    input  logic             inc,
    output logic [SEL_W-1:0] q
);

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_REGS - 1);

    logic [SEL_W-1:0] q_q;
    logic [SEL_W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = load_val;
        end else if (inc) begin
            q_d = (q_q == LAST_IDX) ? '0 : q_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/regbank_loader.sv
// Write sequencer feeding an 8-entry register bank: streams valid/ready words
// into consecutive entries from a programmable start index, wrapping at the top.
module regbank_loader #(
    parameter int W      = 8,
    parameter int N_REGS = regbank_pkg::N_REGS,
    parameter int SEL_W  = regbank_pkg::SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [SEL_W-1:0] start_idx,
    input  logic [SEL_W:0]   length,
    input  logic             in_valid,
    input  logic [W-1:0]     in_data,
    output logic             in_ready,
    output logic [SEL_W-1:0] sel,
    output logic [W-1:0]     wd,
    output logic             we,
    output logic             busy,
    output logic             done
);

    import regbank_pkg::*;

    localparam logic [SEL_W:0] MAX_LEN = (SEL_W + 1)'(N_REGS);
    localparam logic [SEL_W:0] ONE_LEFT = (SEL_W + 1)'(1);

    loader_state_t    state_q, state_d;
    logic [SEL_W:0]   rem_q, rem_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [W-1:0]     wd_q, wd_d;
    logic             we_q, we_d;

    logic [SEL_W:0]   len_clamped;
    logic [SEL_W-1:0] idx;
    logic             idx_load;
    logic             idx_inc;
    logic             xfer;

    assign len_clamped = (length > MAX_LEN) ? MAX_LEN : length;

    wrap_counter #(
        .SEL_W  (SEL_W),
        .N_REGS (N_REGS)
    ) u_idx (
        .clk      (clk),
        .rst      (rst),
        .load     (idx_load),
        .load_val (start_idx),
        .inc      (idx_inc),
        .q        (idx)
    );

    // Ready depends on state alone so upstream never sees a valid->ready loop.
    assign in_ready = (state_q == LOAD);
    assign xfer     = in_valid && in_ready;

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        sel_d    = sel_q;
        wd_d     = wd_q;
        we_d     = 1'b0;
        idx_load = 1'b0;
        idx_inc  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len_clamped == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d  = LOAD;
                        rem_d    = len_clamped;
                        idx_load = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (xfer) begin
                    sel_d   = idx;
                    wd_d    = in_data;
                    we_d    = 1'b1;
                    idx_inc = 1'b1;
                    rem_d   = rem_q - ONE_LEFT;
                    if (rem_q == ONE_LEFT) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            sel_q   <= '0;
            wd_q    <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            sel_q   <= sel_d;
            wd_q    <= wd_d;
            we_q    <= we_d;
        end
    end

    // sel/wd hold between writes so an enable-less bank just rewrites its last value.
    assign sel  = sel_q;
    assign wd   = wd_q;
    assign we   = we_q;
    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_regbank_loader.sv
// Randomized bench for regbank_loader: an emulated bank captures the write port,
// and a transaction-level reference predicts writes, handshake and done timing.
module tb_regbank_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] start_idx;
    logic [3:0] length;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [2:0] sel;
    logic [7:0] wd;
    logic       we;
    logic       busy;
    logic       done;

    int n_total = 0;
    int n_bad   = 0;

    logic [7:0] bank_tb  [8];
    logic [7:0] bank_ref [8];
    logic [2:0] last_sel;
    logic [7:0] last_wd;

    regbank_loader #(.W(8), .N_REGS(8), .SEL_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .start_idx (start_idx),
        .length    (length),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .sel       (sel),
        .wd        (wd),
        .we        (we),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Advance one edge and let the emulated bank capture the write port.
    task automatic tick();
        @(posedge clk);
        #1;
        if (we === 1'b1) bank_tb[sel] = wd;
    endtask

    task automatic check_banks(input string tag);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s_bank%0d", tag, i), bank_tb[i], bank_ref[i]);
        end
    endtask

    // One burst: start pulse in IDLE, then words until the clamped count is consumed.
    // mode 0: random data, 1: data = word number, 2: data = 8'hA0 + word number.
    task automatic burst(input int sidx, input int len, input int mode, input int vpct,
                         input bit use_pat, input logic [15:0] pat, input bit poke);
        int  eff;
        int  sent;
        int  guard;
        bit  prev;
        bit  v;
        logic [7:0] dword;
        eff = (len > 8) ? 8 : len;
        $display("burst idx=%0d len=%0d eff=%0d mode=%0d", sidx, len, eff, mode);
        chk("idle_rdy", in_ready, 1'b0);
        chk("idle_busy", busy, 1'b0);
        start     = 1'b1;
        start_idx = 3'(sidx);
        length    = 4'(len);
        in_valid  = 1'b1;
        in_data   = 8'($urandom);
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        if (eff == 0) begin
            chk("z_done", done, 1'b1);
            chk("z_busy", busy, 1'b1);
            chk("z_rdy", in_ready, 1'b0);
            chk("z_we", we, 1'b0);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            chk("z_done_end", done, 1'b0);
            chk("z_busy_end", busy, 1'b0);
            chk("z_we_end", we, 1'b0);
            chk("z_sel_held", sel, last_sel);
            return;
        end
        sent  = 0;
        guard = 0;
        prev  = 1'b0;
        while (1) begin
            chk("we", we, prev);
            chk("sel", sel, last_sel);
            chk("wd", wd, last_wd);
            if (sent == eff) break;
            chk("load_rdy", in_ready, 1'b1);
            chk("load_busy", busy, 1'b1);
            chk("load_done", done, 1'b0);
            if (use_pat) v = pat[guard];
            else         v = ($urandom_range(99) < vpct);
            case (mode)
                1:       dword = 8'(sent);
                2:       dword = 8'hA0 + 8'(sent);
                default: dword = 8'($urandom);
            endcase
            in_valid  = v;
            in_data   = v ? dword : 8'($urandom);
            start     = poke && (guard == 1);
            start_idx = 3'd5;
            length    = 4'd3;
            tick();
            start    = 1'b0;
            in_valid = 1'b0;
            if (v) begin
                last_sel           = 3'((sidx + sent) % 8);
                last_wd            = dword;
                bank_ref[last_sel] = dword;
                sent++;
            end
            prev = v;
            guard++;
            if (guard > 400) begin
                chk("timeout", 32'(sent), 32'(eff));
                break;
            end
        end
        chk("fin_done", done, 1'b1);
        chk("fin_busy", busy, 1'b1);
        chk("fin_rdy", in_ready, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        tick();
        in_valid = 1'b0;
        chk("post_done", done, 1'b0);
        chk("post_busy", busy, 1'b0);
        chk("post_we", we, 1'b0);
        chk("post_sel", sel, last_sel);
        chk("post_wd", wd, last_wd);
        check_banks("burst");
    endtask

    initial begin
        logic [7:0] d0;
        logic [7:0] d1;
        rst       = 1'b1;
        start     = 1'b0;
        start_idx = '0;
        length    = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        last_sel  = '0;
        last_wd   = '0;
        for (int i = 0; i < 8; i++) begin
            bank_tb[i]  = '0;
            bank_ref[i] = '0;
        end
        tick();
        tick();
        rst = 1'b0;
        chk("rst_sel", sel, 3'd0);
        chk("rst_wd", wd, 8'd0);
        chk("rst_we", we, 1'b0);
        chk("rst_rdy", in_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);

        // Full wrap from 0 with back-to-back words.
        burst(0, 8, 1, 100, 1'b0, 16'h0, 1'b0);
        // Wrapping burst 6,7,0,1.
        burst(6, 4, 2, 100, 1'b0, 16'h0, 1'b0);
        // Zero length, then a clamped oversize length.
        burst(3, 0, 0, 100, 1'b0, 16'h0, 1'b0);
        burst(2, 15, 0, 100, 1'b0, 16'h0, 1'b0);
        // Valid pattern 1,0,0,1,1.
        burst(4, 3, 0, 0, 1'b1, 16'b11001, 1'b0);
        // Start poked mid-burst must be ignored; next burst starts right after done.
        burst(1, 6, 0, 100, 1'b0, 16'h0, 1'b1);
        burst(7, 2, 0, 100, 1'b0, 16'h0, 1'b0);

        for (int k = 0; k < 25; k++) begin
            burst($urandom_range(7), $urandom_range(15), 0, 60, 1'b0, 16'h0, $urandom_range(1) == 1);
        end

        // Reset mid-burst after 2 of 5 words.
        $display("burst idx=2 len=5 reset after 2 words");
        start     = 1'b1;
        start_idx = 3'd2;
        length    = 4'd5;
        tick();
        start    = 1'b0;
        d0       = 8'($urandom);
        d1       = 8'($urandom);
        in_valid = 1'b1;
        in_data  = d0;
        tick();
        bank_ref[2] = d0;
        in_data     = d1;
        tick();
        bank_ref[3] = d1;
        chk("rs_we2", we, 1'b1);
        chk("rs_sel2", sel, 3'd3);
        in_valid = 1'b1;
        rst      = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        last_sel = '0;
        last_wd  = '0;
        chk("rs_rdy", in_ready, 1'b0);
        chk("rs_we", we, 1'b0);
        chk("rs_sel", sel, 3'd0);
        chk("rs_wd", wd, 8'd0);
        chk("rs_done", done, 1'b0);
        chk("rs_busy", busy, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rs_nodone", done, 1'b0);
            chk("rs_nowe", we, 1'b0);
        end
        check_banks("rs");
        burst(5, 3, 0, 100, 1'b0, 16'h0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
